// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - IF/ID fetch handshake between the sequencer and the pipeline register
interface fetch_sequencer_if;
  logic       if_valid;
  logic       if_ready;
  logic [7:0] if_instr;
  logic [7:0] if_pc;

  modport master (output if_valid, output if_instr, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output if_ready);
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller: PC, program store and IF/ID streaming
module fetch_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               load_en,
  input  logic [7:0]         load_addr,
  input  logic [7:0]         load_data,
  input  logic               start,
  fetch_sequencer_if.master  fetch,
  output logic               busy,
  output logic               done,
  output logic [7:0]         fetch_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e     state_q;
  logic [7:0] pc_q, pc_d;
  logic [8:0] prog_len_q, prog_len_d;
  logic       valid_q;
  logic [7:0] instr_q;
  logic [7:0] ipc_q;
  logic [7:0] count_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] mem [DEPTH];

  logic [7:0] rd_word;
  logic       slot_free;
  logic       in_prog;
  logic       load_ok;

  // Jump targets are resolved from the word being issued, so a taken jmp costs no bubble.
  always_comb begin
    rd_word    = mem[pc_q[AW-1:0]];
    slot_free  = !valid_q || fetch.if_ready;
    in_prog    = {1'b0, pc_q} < prog_len_q;
    load_ok    = load_en && ({1'b0, load_addr} < 9'(DEPTH));
    pc_d       = pc_q + 8'd1;
    if (rd_word[7:6] == 2'b11) begin
      pc_d = pc_q + {{2{rd_word[5]}}, rd_word[5:0]};
    end
    prog_len_d = prog_len_q;
    if ({1'b0, load_addr} + 9'd1 > prog_len_q) begin
      prog_len_d = {1'b0, load_addr} + 9'd1;
    end
  end

  // Reset leaves the program store untouched; only prog_len forgets it.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      pc_q       <= 8'd0;
      prog_len_q <= 9'd0;
      valid_q    <= 1'b0;
      instr_q    <= 8'd0;
      ipc_q      <= 8'd0;
      count_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (load_ok) begin
            mem[load_addr[AW-1:0]] <= load_data;
            prog_len_q             <= prog_len_d;
          end
          if (start) begin
            state_q <= RUN;
            pc_q    <= 8'd0;
            count_q <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (slot_free) begin
            if (in_prog) begin
              valid_q <= 1'b1;
              instr_q <= rd_word;
              ipc_q   <= pc_q;
              pc_q    <= pc_d;
              count_q <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            end else begin
              valid_q <= 1'b0;
              state_q <= HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetch.if_valid = valid_q;
  assign fetch.if_instr = instr_q;
  assign fetch.if_pc    = ipc_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic       Clk;
  logic       Reset;
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] fetch_count;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.DEPTH(8)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .fetch       (bus),
    .busy        (busy),
    .done        (done),
    .fetch_count (fetch_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         ld;
    logic [7:0] la;
    logic [7:0] ldat;
    bit         st;
    bit         rdy;
    bit         v;
    logic [7:0] pc;
    logic [7:0] ins;
    bit         b;
    bit         d;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    int pc;
    int ins;
  } word_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Inputs change after a falling edge; outputs are sampled at the next falling edge.
  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  function automatic void addv(bit ld, logic [7:0] la, logic [7:0] ldat, bit st, bit rdy,
                               bit v, logic [7:0] pc, logic [7:0] ins, bit b, bit d,
                               logic [7:0] cnt);
    vec_t r;
    r.ld = ld; r.la = la; r.ldat = ldat; r.st = st; r.rdy = rdy;
    r.v = v; r.pc = pc; r.ins = ins; r.b = b; r.d = d; r.cnt = cnt;
    tbl.push_back(r);
  endfunction

  initial begin
    int     plen;
    int     pc;
    int     off;
    int     idx;
    int     cyc;
    bit     finite;
    bit     r;
    bit     pv, pr;
    logic [7:0] ppc, pins;
    logic [7:0] prog [8];
    word_t  expq[$];
    word_t  w;

    Reset = 1'b0; load_en = 1'b0; load_addr = 8'd0; load_data = 8'd0;
    start = 1'b0; bus.if_ready = 1'b0;
    tick();
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_instr", 32'(bus.if_instr), 32'd0);
    chk("rst_pc",    32'(bus.if_pc),    32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_done",  32'(done),         32'd0);
    chk("rst_count", 32'(fetch_count),  32'd0);
    Reset = 1'b1;

    load(8'd0, 8'h13); load(8'd1, 8'h51); load(8'd2, 8'h2C);
    load(8'd3, 8'hC2); load(8'd4, 8'h6B); load(8'd5, 8'h0A);

    // Run A: straight-through with the jmp at pc 3 skipping pc 4.
    addv(0, 0, 0, 1, 1, 0, 0, 0,     1, 0, 0);
    addv(0, 0, 0, 0, 1, 1, 0, 8'h13, 1, 0, 1);
    addv(0, 0, 0, 0, 1, 1, 1, 8'h51, 1, 0, 2);
    addv(0, 0, 0, 0, 1, 1, 2, 8'h2C, 1, 0, 3);
    addv(0, 0, 0, 0, 1, 1, 3, 8'hC2, 1, 0, 4);
    addv(0, 0, 0, 0, 1, 1, 5, 8'h0A, 1, 0, 5);
    addv(0, 0, 0, 0, 1, 0, 0, 0,     0, 1, 5);
    addv(0, 0, 0, 0, 1, 0, 0, 0,     0, 1, 5);
    // Run B: restart from HALT, stall on pc 2, loads during RUN must be ignored.
    addv(0, 0, 0, 1, 1, 0, 0, 0,     1, 0, 0);
    addv(0, 0, 0, 0, 1, 1, 0, 8'h13, 1, 0, 1);
    addv(0, 0, 0, 0, 1, 1, 1, 8'h51, 1, 0, 2);
    addv(0, 0, 0, 0, 1, 1, 2, 8'h2C, 1, 0, 3);
    addv(1, 4, 8'hFF, 0, 0, 1, 2, 8'h2C, 1, 0, 3);
    addv(1, 7, 8'h00, 0, 0, 1, 2, 8'h2C, 1, 0, 3);
    addv(0, 0, 0, 0, 0, 1, 2, 8'h2C, 1, 0, 3);
    addv(0, 0, 0, 0, 1, 1, 3, 8'hC2, 1, 0, 4);
    addv(0, 0, 0, 0, 1, 1, 5, 8'h0A, 1, 0, 5);
    addv(0, 0, 0, 0, 1, 0, 0, 0,     0, 1, 5);
    // Run C: out-of-range write ignored; load+start together replaces the jmp.
    addv(1, 8, 8'hC0, 0, 1, 0, 0, 0, 0, 1, 5);
    addv(1, 3, 8'h00, 1, 1, 0, 0, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 1, 1, 0, 8'h13, 1, 0, 1);
    addv(0, 0, 0, 0, 1, 1, 1, 8'h51, 1, 0, 2);
    addv(0, 0, 0, 0, 1, 1, 2, 8'h2C, 1, 0, 3);
    addv(0, 0, 0, 0, 1, 1, 3, 8'h00, 1, 0, 4);
    addv(0, 0, 0, 0, 1, 1, 4, 8'h6B, 1, 0, 5);
    addv(0, 0, 0, 0, 1, 1, 5, 8'h0A, 1, 0, 6);
    addv(0, 0, 0, 0, 1, 0, 0, 0,     0, 1, 6);

    for (int i = 0; i < tbl.size(); i++) begin
      load_en = tbl[i].ld; load_addr = tbl[i].la; load_data = tbl[i].ldat;
      start = tbl[i].st; bus.if_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.if_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_busy", i),  32'(busy),         32'(tbl[i].b));
      chk($sformatf("vec%0d_done", i),  32'(done),         32'(tbl[i].d));
      chk($sformatf("vec%0d_count", i), 32'(fetch_count),  32'(tbl[i].cnt));
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_pc", i),    32'(bus.if_pc),    32'(tbl[i].pc));
        chk($sformatf("vec%0d_instr", i), 32'(bus.if_instr), 32'(tbl[i].ins));
      end
    end
    load_en = 1'b0; start = 1'b0;

    // jmp +0 spins on pc 0 and saturates the count; Reset drops a stalled word.
    Reset = 1'b0; tick(); Reset = 1'b1;
    load(8'd0, 8'hC0);
    start = 1'b1; bus.if_ready = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("spin_valid", 32'(bus.if_valid), 32'd1);
      chk("spin_pc",    32'(bus.if_pc),    32'd0);
      chk("spin_busy",  32'(busy),         32'd1);
      chk("spin_count", 32'(fetch_count),  32'((i + 1 > 255) ? 255 : i + 1));
    end
    bus.if_ready = 1'b0; tick(); tick();
    chk("stall_valid", 32'(bus.if_valid), 32'd1);
    Reset = 1'b0; tick(); Reset = 1'b1;
    chk("mid_rst_valid", 32'(bus.if_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),         32'd0);
    chk("mid_rst_done",  32'(done),         32'd0);
    chk("mid_rst_count", 32'(fetch_count),  32'd0);

    // prog_len cleared by Reset: a start with nothing loaded halts at once.
    bus.if_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    chk("empty_busy", 32'(busy), 32'd1);
    tick();
    chk("empty_done",  32'(done),         32'd1);
    chk("empty_valid", 32'(bus.if_valid), 32'd0);
    chk("empty_count", 32'(fetch_count),  32'd0);

    // Jump out of the one-word program halts on the following attempt.
    load(8'd0, 8'hDF);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("oor_valid", 32'(bus.if_valid), 32'd1);
    chk("oor_pc",    32'(bus.if_pc),    32'd0);
    chk("oor_instr", 32'(bus.if_instr), 32'hDF);
    tick();
    chk("oor_done",  32'(done),         32'd1);
    chk("oor_valid2", 32'(bus.if_valid), 32'd0);
    chk("oor_count", 32'(fetch_count),  32'd1);

    // Random programs against a program-walk model with random back-pressure.
    for (int it = 0; it < 25; it++) begin
      Reset = 1'b0; bus.if_ready = 1'b0; tick(); Reset = 1'b1;
      plen = $urandom_range(1, 8);
      for (int a = 0; a < 8; a++) begin
        if ($urandom_range(0, 3) == 0) begin
          off = $urandom_range(0, 8) - 4;
          prog[a] = {2'b11, 6'(off)};
        end else begin
          prog[a] = 8'($urandom_range(0, 191));
        end
      end
      for (int a = plen - 1; a >= 0; a--) begin
        load(8'(a), prog[a]);
        if ($urandom_range(0, 2) == 0) load(8'($urandom_range(8, 255)), 8'hC0);
      end
      expq.delete();
      pc = 0;
      finite = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (pc >= plen) begin
          finite = 1'b1;
          break;
        end
        w.pc = pc; w.ins = int'(prog[pc]);
        expq.push_back(w);
        if (prog[pc][7:6] == 2'b11) begin
          off = int'($signed(prog[pc][5:0]));
          pc  = (pc + off) & 255;
        end else begin
          pc = (pc + 1) & 255;
        end
      end

      start = 1'b1; bus.if_ready = 1'b1; tick(); start = 1'b0;
      idx = 0; pv = 1'b0; pr = 1'b0; ppc = 8'd0; pins = 8'd0;
      for (cyc = 0; cyc < 1000; cyc++) begin
        if (busy && done) chk("rnd_busy_done", 32'd1, 32'd0);
        if (pv && !pr) begin
          chk("rnd_hold_valid", 32'(bus.if_valid), 32'd1);
          chk("rnd_hold_pc",    32'(bus.if_pc),    32'(ppc));
          chk("rnd_hold_instr", 32'(bus.if_instr), 32'(pins));
        end
        if (done) break;
        if (!finite && idx >= 300) break;
        r = ($urandom_range(0, 3) != 0);
        bus.if_ready = r;
        if (bus.if_valid && r) begin
          if (idx < expq.size()) begin
            chk("rnd_pc",    32'(bus.if_pc),    32'(expq[idx].pc));
            chk("rnd_instr", 32'(bus.if_instr), 32'(expq[idx].ins));
          end else begin
            chk("rnd_extra_word", 32'(idx), 32'(expq.size()));
          end
          idx++;
        end
        pv = bus.if_valid; pr = r; ppc = bus.if_pc; pins = bus.if_instr;
        tick();
      end
      if (finite) begin
        chk("rnd_done",  32'(done),        32'd1);
        chk("rnd_words", 32'(idx),         32'(expq.size()));
        chk("rnd_count", 32'(fetch_count), 32'((expq.size() > 255) ? 255 : expq.size()));
      end else begin
        chk("rnd_loop_busy", 32'(busy), 32'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
